// File: rtl/board.sv
// 5x5 two-player placement board.
// Each place rise commits at most one legal move into an empty cell.
module board (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        select_player,
  input  logic        player2Select,
  input  logic        enable_player,
  input  logic        player2Enable,
  input  logic [17:0] playerLocation,
  input  logic        place,
  output logic [1:0]  board1,
  output logic [1:0]  board2,
  output logic [1:0]  board3,
  output logic [1:0]  board4,
  output logic [1:0]  board5,
  output logic [1:0]  board6,
  output logic [1:0]  board7,
  output logic [1:0]  board8,
  output logic [1:0]  board9,
  output logic [1:0]  board10,
  output logic [1:0]  board11,
  output logic [1:0]  board12,
  output logic [1:0]  board13,
  output logic [1:0]  board14,
  output logic [1:0]  board15,
  output logic [1:0]  board16,
  output logic [1:0]  board17,
  output logic [1:0]  board18,
  output logic [1:0]  board19,
  output logic [1:0]  board20,
  output logic [1:0]  board21,
  output logic [1:0]  board22,
  output logic [1:0]  board23,
  output logic [1:0]  board24,
  output logic [1:0]  board25,
  output logic        player_done,
  output logic        player2Done
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  logic [1:0] cells [25];
  logic       place_q;
  logic [4:0] moves;
  logic       p1_done;
  logic       p2_done;

  logic       rise;
  logic       p1_act;
  logic       p2_act;
  logic       loc_ok;
  logic [4:0] idx;
  logic       free;
  logic       commit;

  always_comb begin
    rise   = place & ~place_q;
    p1_act = select_player & enable_player;
    p2_act = player2Select & player2Enable;
    loc_ok = (playerLocation != 18'd0) &&
             (playerLocation <= 18'd25);
    idx    = loc_ok ? (playerLocation[4:0] - 5'd1) : 5'd0;
    free   = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (idx == 5'(i)) free = (cells[i] == EMPTY);
    end
    commit = rise & (p1_act ^ p2_act) & loc_ok
           & free & (moves != 5'd25);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      place_q <= 1'b0;
      moves   <= 5'd0;
      p1_done <= 1'b0;
      p2_done <= 1'b0;
      for (int i = 0; i < 25; i++) cells[i] <= EMPTY;
    end else begin
      place_q <= place;
      if (clr) begin
        moves   <= 5'd0;
        p1_done <= 1'b0;
        p2_done <= 1'b0;
        for (int i = 0; i < 25; i++) cells[i] <= EMPTY;
      end else begin
        p1_done <= commit & p1_act;
        p2_done <= commit & p2_act;
        if (commit) begin
          moves <= moves + 5'd1;
          for (int i = 0; i < 25; i++) begin
            if (idx == 5'(i)) cells[i] <= p1_act ? P1 : P2;
          end
        end
      end
    end
  end

  assign player_done = p1_done;
  assign player2Done = p2_done;

  assign board1  = cells[0];
  assign board2  = cells[1];
  assign board3  = cells[2];
  assign board4  = cells[3];
  assign board5  = cells[4];
  assign board6  = cells[5];
  assign board7  = cells[6];
  assign board8  = cells[7];
  assign board9  = cells[8];
  assign board10 = cells[9];
  assign board11 = cells[10];
  assign board12 = cells[11];
  assign board13 = cells[12];
  assign board14 = cells[13];
  assign board15 = cells[14];
  assign board16 = cells[15];
  assign board17 = cells[16];
  assign board18 = cells[17];
  assign board19 = cells[18];
  assign board20 = cells[19];
  assign board21 = cells[20];
  assign board22 = cells[21];
  assign board23 = cells[22];
  assign board24 = cells[23];
  assign board25 = cells[24];

endmodule

// File: tb/tb_board.sv
// Bench for board: directed scenarios plus random traffic
// checked against a cell-array reference model.
module tb_board;

  logic        clk = 1'b0;
  logic        rst, clr, sel1, sel2, en1, en2, place;
  logic [17:0] loc;
  logic [1:0]  b [25];
  logic        done1, done2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] m_cells [25];
  int         m_cnt;
  logic       m_pq;
  logic       m_d1, m_d2;

  always #5 clk = ~clk;

  board dut (
    .clk(clk), .rst(rst), .clr(clr),
    .select_player(sel1), .player2Select(sel2),
    .enable_player(en1), .player2Enable(en2),
    .playerLocation(loc), .place(place),
    .board1(b[0]),   .board2(b[1]),   .board3(b[2]),
    .board4(b[3]),   .board5(b[4]),   .board6(b[5]),
    .board7(b[6]),   .board8(b[7]),   .board9(b[8]),
    .board10(b[9]),  .board11(b[10]), .board12(b[11]),
    .board13(b[12]), .board14(b[13]), .board15(b[14]),
    .board16(b[15]), .board17(b[16]), .board18(b[17]),
    .board19(b[18]), .board20(b[19]), .board21(b[20]),
    .board22(b[21]), .board23(b[22]), .board24(b[23]),
    .board25(b[24]),
    .player_done(done1), .player2Done(done2)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_dut();
    logic [63:0] v = '0;
    for (int i = 0; i < 25; i++) v[2*i +: 2] = b[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] v = '0;
    for (int i = 0; i < 25; i++) v[2*i +: 2] = m_cells[i];
    return v;
  endfunction

  // One clock: predict from the rules, advance, compare.
  task automatic step(input string tag);
    bit a1, a2, rise, legal;
    int li;
    a1   = sel1 && en1;
    a2   = sel2 && en2;
    rise = place && !m_pq;
    li   = int'(loc);
    legal = rise && (a1 != a2) && li >= 1 && li <= 25
            && m_cnt < 25;
    if (legal) legal = (m_cells[li-1] == 2'b00);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 25; i++) m_cells[i] = 2'b00;
      m_cnt = 0; m_pq = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      m_pq = place;
      if (clr) begin
        for (int i = 0; i < 25; i++) m_cells[i] = 2'b00;
        m_cnt = 0; m_d1 = 0; m_d2 = 0;
      end else begin
        m_d1 = legal && a1;
        m_d2 = legal && a2;
        if (legal) begin
          m_cells[li-1] = a1 ? 2'b01 : 2'b10;
          m_cnt++;
        end
      end
    end
    check({tag, ".cells"}, pack_dut(), pack_model());
    check({tag, ".done1"}, 64'(done1), 64'(m_d1));
    check({tag, ".done2"}, 64'(done2), 64'(m_d2));
  endtask

  task automatic set_player(input int p);
    sel1 = (p == 1 || p == 3);
    en1  = (p == 1 || p == 3);
    sel2 = (p == 2 || p == 3);
    en2  = (p == 2 || p == 3);
  endtask

  task automatic move(input int p, input int l, input string tag);
    set_player(p);
    loc   = 18'(l);
    place = 1'b0;
    step({tag, ".low"});
    place = 1'b1;
    step({tag, ".rise"});
    place = 1'b0;
    step({tag, ".after"});
  endtask

  initial begin
    rst = 1; clr = 0; place = 0; loc = 0;
    set_player(0);
    m_pq = 0; m_cnt = 0; m_d1 = 0; m_d2 = 0;
    for (int i = 0; i < 25; i++) m_cells[i] = 2'b00;
    #2;
    step("reset0");
    step("reset1");
    rst = 0;

    move(1, 2, "p1_at2");
    check("board2_is_p1", 64'(b[1]), 64'd1);
    move(2, 1, "p2_at1");
    check("board1_is_p2", 64'(b[0]), 64'd2);
    move(1, 3, "p1_at3");
    move(2, 4, "p2_at4");
    move(2, 3, "p2_occupied");
    check("board3_kept", 64'(b[2]), 64'd1);

    move(3, 5, "both_active");
    move(0, 5, "none_active");
    move(1, 0, "loc0");
    move(1, 26, "loc26");
    set_player(1);
    loc = 18'd6;
    place = 1'b1;
    for (int i = 0; i < 5; i++) step("held_high");
    loc = 18'd7;
    step("held_newloc");
    place = 1'b0;
    step("held_release");

    set_player(2);
    loc = 18'd10;
    clr = 1'b1;
    place = 1'b1;
    step("clr_with_rise");
    check("clr_empty", pack_dut(), 64'd0);
    clr = 1'b0;
    place = 1'b0;
    step("clr_after");

    for (int i = 1; i <= 25; i++)
      move((i % 2) ? 1 : 2, i, "fill");
    move(1, 1, "req26");
    rst = 1'b1;
    place = 1'b1;
    step("rst_full");
    check("rst_empty", pack_dut(), 64'd0);
    rst = 1'b0;
    set_player(1);
    loc = 18'd13;
    step("rise_after_rst");

    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      sel1  = 1'($urandom);
      en1   = 1'($urandom);
      sel2  = 1'($urandom);
      en2   = 1'($urandom);
      loc   = 18'($urandom_range(0, 27));
      place = 1'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board.md
BOARD -- requirements
Module: board

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port clr, input, 1 bit: synchronous board clear, active-high.
REQ-004 The block SHALL have the port select_player, input, 1 bit: player 1 selected.
REQ-005 The block SHALL have the port player2Select, input, 1 bit: player 2 selected.
REQ-006 The block SHALL have the port enable_player, input, 1 bit: player 1 move enable.
REQ-007 The block SHALL have the port player2Enable, input, 1 bit: player 2 move enable.
REQ-008 The block SHALL have the port playerLocation, input, 18 bits: target cell index, unsigned; 1..25 valid.
REQ-009 The block SHALL have the port place, input, 1 bit: move strobe; commits on a detected 0->1 transition.
REQ-010 The block SHALL have the ports board1..board25, output, 2 bits each: cell state, row-major 5x5 grid, board1 = top-left.
REQ-011 The block SHALL have the port player_done, output, 1 bit: one-cycle pulse when a player 1 move commits.
REQ-012 The block SHALL have the port player2Done, output, 1 bit: one-cycle pulse when a player 2 move commits.

Function
REQ-013 Cell encoding SHALL be: 2'b00 empty, 2'b01 player 1, 2'b10 player 2; 2'b11 SHALL never be produced.
REQ-014 The block SHALL register place every cycle (place_q) and detect a rise when place=1 and place_q=0.
REQ-015 P1 active SHALL be select_player & enable_player; P2 active SHALL be player2Select & player2Enable.
REQ-016 A move SHALL commit on the clock edge where a rise is detected, exactly one of P1/P2 is active, playerLocation is 1..25, and the addressed cell is 00.
REQ-017 On commit, the addressed cell SHALL become 01 (P1) or 10 (P2), visible on boardN immediately after that edge.
REQ-018 On a P1 commit, player_done SHALL be 1 for exactly the cycle following the commit edge; on a P2 commit, player2Done SHALL likewise be 1; otherwise both SHALL be 0.
REQ-019 A move request SHALL be ignored, with no cell change and no done pulse, if it occurs with: both players active, neither player active, playerLocation = 0 or > 25, or an occupied target cell.
REQ-020 At most one move SHALL commit per place rise; holding place high SHALL not commit further moves.
REQ-021 The block SHALL maintain an internal 5-bit move counter, incremented per commit, saturating at 25; no move SHALL commit when it equals 25.
REQ-022 When clr=1, on the clock edge all cells SHALL become 00, the move counter SHALL become 0, both done outputs SHALL become 0, and any simultaneous move SHALL be discarded; place_q SHALL still update.
REQ-023 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-024 When rst=1 on a clock edge, all 25 cells SHALL become 00, player_done and player2Done SHALL become 0, the move counter SHALL become 0, and place_q SHALL become 0.
REQ-025 rst SHALL take priority over clr and over any move request.
REQ-026 A place level of 1 on the first edge after reset is released SHALL count as a rise, because place_q=0.

Verification
REQ-027 Scenario: P1 active, playerLocation=2, place rises -> board2=01 and player_done pulses for 1 cycle; all other cells 00.
REQ-028 Scenario: then P2 active, playerLocation=1, place rises -> board1=10 and player2Done pulses; board2 stays 01.
REQ-029 Scenario: P1 at 3, then P2 at 4 -> board1..4 = 10,01,01,10; a P2 attempt on cell 3 is ignored, with no pulse and board3=01.
REQ-030 Scenario: illegal requests (both players active, location 0, location 26, place held high for 5 cycles) -> at most the single legal commit occurs; no extra changes.
REQ-031 Scenario: clr=1 for 1 cycle with a populated board and a simultaneous place rise -> all cells 00 and no done pulse.
REQ-032 Scenario: fill all 25 cells alternately, then issue a 26th request -> ignored; then rst=1 -> all cells 00 and both done outputs 0.
